// File: rtl/edge_drawer_pkg.sv
// Shared definitions for the edge drawer: etype bit positions, frame geometry,
// FSM state encoding and the degenerate-edge test.
// Latency: n/a (definitions only). Backpressure: n/a.
package edge_drawer_pkg;

    // etype bit positions
    localparam int ET_VERT = 0;
    localparam int ET_HORZ = 1;
    localparam int ET_INV  = 2;

    // Frame geometry: 128 columns x 64 rows, address = {y, x}
    localparam int X_W    = 7;
    localparam int Y_W    = 6;
    localparam int ADDR_W = X_W + Y_W;
    localparam logic [X_W-1:0] X_MAX = 7'd127;
    localparam logic [Y_W-1:0] Y_MAX = 6'd63;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DRAW   = 2'b01,
        ST_DONE   = 2'b10,
        ST_SETTLE = 2'b11
    } state_e;

    // An edge that walks backwards has nothing to draw.
    function automatic logic is_degenerate(
        input logic [1:0]     dir,
        input logic [X_W-1:0] xs,
        input logic [X_W-1:0] xe,
        input logic [Y_W-1:0] ys,
        input logic [Y_W-1:0] ye
    );
        return (dir[ET_VERT] && (ys > ye)) || (dir[ET_HORZ] && (xs > xe));
    endfunction

endpackage

// File: rtl/edge_drawer_walker.sv
// edge_walker: coordinate counter for one edge, with the end-of-edge compare.
// Latency: loads on load_i, steps one pixel per accepted write (adv_i).
// Backpressure: coordinates hold while adv_i is low, so a stalled pixel is kept.
// Ports: clk_i/rst_ni clock and async active-low reset; load_i captures
//        start/end coordinates and direction; adv_i marks a completed write;
//        cur_x_o/cur_y_o current pixel; at_end_o current pixel is the last one.
module edge_walker
    import edge_drawer_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           load_i,
    input  logic           adv_i,
    input  logic           vert_i,
    input  logic [X_W-1:0] xstart_i,
    input  logic [X_W-1:0] xend_i,
    input  logic [Y_W-1:0] ystart_i,
    input  logic [Y_W-1:0] yend_i,
    output logic [X_W-1:0] cur_x_o,
    output logic [Y_W-1:0] cur_y_o,
    output logic           at_end_o
);

    logic [X_W-1:0] cur_x_q, cur_x_d, end_x_q, end_x_d;
    logic [Y_W-1:0] cur_y_q, cur_y_d, end_y_q, end_y_d;
    logic           vert_q, vert_d;

    // The end compare is made before any increment, so the walker never
    // steps past the frame edge.
    assign at_end_o = vert_q ? (cur_y_q == end_y_q) : (cur_x_q == end_x_q);
    assign cur_x_o  = cur_x_q;
    assign cur_y_o  = cur_y_q;

    always_comb begin
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        end_x_d = end_x_q;
        end_y_d = end_y_q;
        vert_d  = vert_q;
        if (load_i) begin
            cur_x_d = xstart_i;
            cur_y_d = ystart_i;
            end_x_d = xend_i;
            end_y_d = yend_i;
            vert_d  = vert_i;
        end else if (adv_i && !at_end_o) begin
            // Frame-max guard keeps the counter saturated even if the end
            // registers were ever loaded inconsistently.
            if (vert_q) begin
                if (cur_y_q != Y_MAX) cur_y_d = cur_y_q + 1'b1;
            end else begin
                if (cur_x_q != X_MAX) cur_x_d = cur_x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_x_q <= '0;
            cur_y_q <= '0;
            end_x_q <= '0;
            end_y_q <= '0;
            vert_q  <= 1'b0;
        end else begin
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            end_x_q <= end_x_d;
            end_y_q <= end_y_d;
            vert_q  <= vert_d;
        end
    end

endmodule

// File: rtl/edge_drawer.sv
// edge_drawer: rasterizes one axis-aligned edge into the 128x64 frame buffer.
// Latency: first write one cycle after the edge is seen; donedge one cycle after the last write.
// Backpressure: wr_en/wr_addr/wr_data hold while wr_ready is low; stalls indefinitely.
// Ports: clock/reset (async active-low); xstart/xend/ystart/yend/etype/color edge
//        description from the calculator; wr_ready grant; wr_en/wr_addr/wr_data
//        pixel write; donedge one-cycle finish pulse; busy high outside IDLE.
module edge_drawer
    import edge_drawer_pkg::*;
#(
    parameter int SETTLE  = 2,
    parameter int COLOR_W = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [X_W-1:0]     xstart,
    input  logic [X_W-1:0]     xend,
    input  logic [Y_W-1:0]     ystart,
    input  logic [Y_W-1:0]     yend,
    input  logic [2:0]         etype,
    input  logic [COLOR_W-1:0] color,
    input  logic               wr_ready,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [COLOR_W-1:0] wr_data,
    output logic               donedge,
    output logic               busy
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    state_e             state_q;
    logic               wr_en_q;
    logic               donedge_q;
    logic [COLOR_W-1:0] col_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [X_W-1:0] cur_x;
    logic [Y_W-1:0] cur_y;
    logic           at_end;

    // 01 = vertical, 10 = horizontal; 11 is treated the same as no edge.
    logic edge_present, skip_edge, start_draw, wr_done;

    assign edge_present = etype[ET_VERT] ^ etype[ET_HORZ];
    assign skip_edge    = etype[ET_INV] |
                          is_degenerate(etype[1:0], xstart, xend, ystart, yend);
    assign start_draw   = (state_q == ST_IDLE) && edge_present && !skip_edge;
    // wr_en_q is only ever high in DRAW, so this is the completed-write strobe.
    assign wr_done      = wr_en_q && wr_ready;

    edge_walker u_walker (
        .clk_i    (clock),
        .rst_ni   (reset),
        .load_i   (start_draw),
        .adv_i    (wr_done),
        .vert_i   (etype[ET_VERT]),
        .xstart_i (xstart),
        .xend_i   (xend),
        .ystart_i (ystart),
        .yend_i   (yend),
        .cur_x_o  (cur_x),
        .cur_y_o  (cur_y),
        .at_end_o (at_end)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            wr_en_q   <= 1'b0;
            donedge_q <= 1'b0;
            col_q     <= '0;
            cnt_q     <= '0;
        end else begin
            donedge_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (edge_present) begin
                        col_q <= color;
                        if (skip_edge) begin
                            state_q   <= ST_DONE;
                            donedge_q <= 1'b1;
                        end else begin
                            state_q <= ST_DRAW;
                            wr_en_q <= 1'b1;
                        end
                    end
                end
                ST_DRAW: begin
                    if (wr_done && at_end) begin
                        state_q   <= ST_DONE;
                        wr_en_q   <= 1'b0;
                        donedge_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (SETTLE == 0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_SETTLE;
                        cnt_q   <= CNT_W'(SETTLE);
                    end
                end
                ST_SETTLE: begin
                    // Leave on the cycle the count hits zero, giving the
                    // calculator SETTLE cycles to present its next edge.
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = {cur_y, cur_x};
    assign wr_data = col_q;
    assign donedge = donedge_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_edge_drawer.sv
module tb_edge_drawer;

    localparam int TB_SETTLE = 2;
    localparam int LIMIT     = 3000;

    logic       clock   = 1'b0;
    logic       reset   = 1'b0;
    logic [6:0] xstart  = '0;
    logic [6:0] xend    = '0;
    logic [5:0] ystart  = '0;
    logic [5:0] yend    = '0;
    logic [2:0] etype   = '0;
    logic [2:0] color   = '0;
    logic       wr_ready;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [2:0]  wr_data;
    logic        donedge;
    logic        busy;

    edge_drawer #(.SETTLE(TB_SETTLE), .COLOR_W(3)) dut (
        .clock    (clock),
        .reset    (reset),
        .xstart   (xstart),
        .xend     (xend),
        .ystart   (ystart),
        .yend     (yend),
        .etype    (etype),
        .color    (color),
        .wr_ready (wr_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .donedge  (donedge),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Observation log, sampled mid-cycle on the falling edge.
    typedef struct {
        int          c;
        logic [12:0] a;
        logic [2:0]  d;
        logic        r;
    } wr_t;
    wr_t wr_log[$];
    int  done_q[$];
    bit  busy_at[int];

    always @(negedge clock) begin
        busy_at[cyc] = busy;
        if (wr_en === 1'b1) wr_log.push_back('{cyc, wr_addr, wr_data, wr_ready});
        if (donedge === 1'b1) done_q.push_back(cyc);
    end

    // wr_ready driver: directed pattern relative to pat_start, else random or high.
    int pat_start = -100;
    int pat_len   = 0;
    bit pat [0:7];
    bit rdy_random = 1'b0;

    initial begin
        wr_ready = 1'b1;
        forever begin
            @(posedge clock);
            #2;
            if ((cyc - pat_start) >= 0 && (cyc - pat_start) < pat_len)
                wr_ready = pat[cyc - pat_start];
            else if (rdy_random)
                wr_ready = ($urandom_range(0, 9) < 7);
            else
                wr_ready = 1'b1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: the pixel list an edge must produce, straight from the edge rules.
    logic [12:0] exp_px[$];

    task automatic add_pixels(input logic [6:0] xs, input logic [6:0] xe,
                              input logic [5:0] ys, input logic [5:0] ye,
                              input logic [2:0] et);
        if (et[2] == 1'b0 && et[1:0] == 2'b01)
            for (int y = int'(ys); y <= int'(ye); y++) exp_px.push_back({6'(y), xs});
        if (et[2] == 1'b0 && et[1:0] == 2'b10)
            for (int x = int'(xs); x <= int'(xe); x++) exp_px.push_back({ys, 7'(x)});
    endtask

    int log_base  = 0;
    int done_base = 0;

    // Present one edge for a single cycle, then scramble the coordinates.
    task automatic present(input logic [6:0] xs, input logic [6:0] xe,
                           input logic [5:0] ys, input logic [5:0] ye,
                           input logic [2:0] et, input logic [2:0] col, output int t);
        @(posedge clock);
        #1;
        xstart = xs; xend = xe; ystart = ys; yend = ye; etype = et; color = col;
        t = cyc;
        log_base  = wr_log.size();
        done_base = done_q.size();
        @(posedge clock);
        #1;
        etype  = 3'b000;
        xstart = 7'($urandom_range(0, 127));
        xend   = 7'($urandom_range(0, 127));
        ystart = 6'($urandom_range(0, 63));
        yend   = 6'($urandom_range(0, 63));
        color  = 3'($urandom_range(0, 7));
    endtask

    task automatic check_edge(input string tag, input int t,
                              input logic [6:0] xs, input logic [6:0] xe,
                              input logic [5:0] ys, input logic [5:0] ye,
                              input logic [2:0] et, input logic [2:0] col);
        int  lim, n_wr, n_done, dc, k, n_px;
        bit  pres;
        wr_t e;
        exp_px.delete();
        add_pixels(xs, xe, ys, ye, et);
        n_px = exp_px.size();
        pres = (et[1:0] == 2'b01) || (et[1:0] == 2'b10);
        lim  = 0;
        if (pres) begin
            while (lim < LIMIT &&
                   !(done_q.size() > done_base && cyc > done_q[done_base] + TB_SETTLE + 1)) begin
                @(negedge clock);
                lim++;
            end
        end else begin
            repeat (6) @(negedge clock);
        end
        n_wr   = wr_log.size() - log_base;
        n_done = done_q.size() - done_base;
        if (!pres) begin
            chk({tag, "_no_writes"}, n_wr, 0);
            chk({tag, "_no_done"}, n_done, 0);
            chk({tag, "_stays_idle"}, 32'(busy_at[t + 1]), 0);
        end else begin
            chk({tag, "_done_count"}, n_done, 1);
            if (n_done > 0) begin
                dc = done_q[done_base];
                k  = 0;
                for (int i = 0; i < n_wr; i++) begin
                    e = wr_log[log_base + i];
                    if (k >= n_px) begin
                        chk({tag, "_wr_en_cycles"}, n_wr, i);
                        break;
                    end
                    chk({tag, "_wr_cycle"}, e.c, t + 1 + i);
                    chk({tag, "_wr_addr"}, 32'(e.a), 32'(exp_px[k]));
                    chk({tag, "_wr_data"}, 32'(e.d), 32'(col));
                    if (e.r) k++;
                end
                chk({tag, "_pixels"}, k, n_px);
                chk({tag, "_done_cycle"}, dc, t + 1 + n_wr);
                for (int s = 1; s <= TB_SETTLE; s++)
                    chk({tag, "_busy_settle"}, 32'(busy_at[dc + s]), 1);
                chk({tag, "_busy_idle"}, 32'(busy_at[dc + TB_SETTLE + 1]), 0);
            end
        end
    endtask

    task automatic run_edge(input string tag, input logic [6:0] xs, input logic [6:0] xe,
                            input logic [5:0] ys, input logic [5:0] ye,
                            input logic [2:0] et, input logic [2:0] col);
        int t;
        present(xs, xe, ys, ye, et, col, t);
        check_edge(tag, t, xs, xe, ys, ye, et, col);
    endtask

    // Calculator's edge ordering for a square of side s at (x0, y0).
    task automatic edge_of(input int i, input int x0, input int y0, input int s,
                           output logic [6:0] xs, output logic [6:0] xe,
                           output logic [5:0] ys, output logic [5:0] ye,
                           output logic [2:0] et);
        case (i)
            0:       begin xs = 7'(x0);     xe = 7'(x0 + s); ys = 6'(y0);     ye = 6'(y0);     et = 3'b010; end
            1:       begin xs = 7'(x0 + s); xe = 7'(x0 + s); ys = 6'(y0);     ye = 6'(y0 + s); et = 3'b001; end
            2:       begin xs = 7'(x0);     xe = 7'(x0 + s); ys = 6'(y0 + s); ye = 6'(y0 + s); et = 3'b010; end
            default: begin xs = 7'(x0);     xe = 7'(x0);     ys = 6'(y0);     ye = 6'(y0 + s); et = 3'b001; end
        endcase
    endtask

    task automatic run_square(input int x0, input int y0, input int s, input logic [2:0] col);
        int idx, tail, sq_c, lb, db, nw;
        bit seen;
        logic [6:0] xs, xe;
        logic [5:0] ys, ye;
        logic [2:0] et;
        idx = 0; tail = 0; sq_c = -1; seen = 1'b0;
        lb = wr_log.size();
        db = done_q.size();
        exp_px.delete();
        for (int i = 0; i < 4; i++) begin
            edge_of(i, x0, y0, s, xs, xe, ys, ye, et);
            add_pixels(xs, xe, ys, ye, et);
        end
        for (int n = 0; n < LIMIT && !(idx == 4 && tail > TB_SETTLE + 3); n++) begin
            @(posedge clock);
            #1;
            // Output register reflects the state before this edge's update.
            if (idx < 4) begin
                edge_of(idx, x0, y0, s, xs, xe, ys, ye, et);
                xstart = xs; xend = xe; ystart = ys; yend = ye; etype = et; color = col;
            end else begin
                etype = 3'b000;
            end
            if (seen) idx++;
            @(negedge clock);
            seen = donedge;
            if (donedge && idx == 3) sq_c = cyc;
            if (idx == 4) tail++;
        end
        chk("square_done_count", done_q.size() - db, 4);
        if (done_q.size() - db >= 4) chk("square_donesquare_align", done_q[db + 3], sq_c);
        nw = 0;
        for (int i = lb; i < wr_log.size(); i++) begin
            if (wr_log[i].r) begin
                if (nw < exp_px.size()) begin
                    chk("square_addr", 32'(wr_log[i].a), 32'(exp_px[nw]));
                    chk("square_data", 32'(wr_log[i].d), 32'(col));
                end
                nw++;
            end
        end
        chk("square_writes", nw, exp_px.size());
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int t, lb, db;
        logic [6:0] rxs, rxe;
        logic [5:0] rys, rye;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_donedge", 32'(donedge), 0);
        chk("rst_busy", 32'(busy), 0);
        #2 reset = 1'b1;

        // Directed edges
        run_edge("vert4", 7'd10, 7'd10, 6'd5, 6'd8, 3'b001, 3'd5);
        run_edge("horz_max", 7'd120, 7'd127, 6'd63, 6'd63, 3'b010, 3'd3);
        run_edge("invalid", 7'd10, 7'd10, 6'd5, 6'd8, 3'b101, 3'd1);
        run_edge("degenerate", 7'd40, 7'd30, 6'd2, 6'd2, 3'b010, 3'd6);
        run_edge("single_px", 7'd0, 7'd0, 6'd0, 6'd0, 3'b001, 3'd7);
        run_edge("type11", 7'd1, 7'd9, 6'd1, 6'd9, 3'b011, 3'd2);

        // Stall: wr_ready 1,0,0,1,1 over the write cycles
        pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b0; pat[3] = 1'b0;
        pat[4] = 1'b1; pat[5] = 1'b1; pat_len = 6;
        present(7'd3, 7'd5, 6'd12, 6'd12, 3'b010, 3'd4, t);
        pat_start = t;
        check_edge("stall", t, 7'd3, 7'd5, 6'd12, 6'd12, 3'b010, 3'd4);
        pat_len = 0;

        // Reset mid-DRAW at pixel 2 of 6
        present(7'd20, 7'd25, 6'd7, 6'd7, 3'b010, 3'd2, t);
        lb = log_base;
        db = done_base;
        @(posedge clock);
        #3;
        chk("midrst_pre_wr_en", 32'(wr_en), 1);
        chk("midrst_pre_addr", 32'(wr_addr), 32'({6'd7, 7'd21}));
        reset = 1'b0;
        #1;
        chk("midrst_wr_en", 32'(wr_en), 0);
        chk("midrst_donedge", 32'(donedge), 0);
        chk("midrst_busy", 32'(busy), 0);
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        repeat (6) @(negedge clock);
        chk("midrst_no_done", done_q.size() - db, 0);
        chk("midrst_writes", wr_log.size() - lb, 1);
        chk("midrst_idle", 32'(busy), 0);

        // Four-edge square from the calculator model
        rdy_random = 1'b1;
        run_square(int'($urandom_range(0, 100)), int'($urandom_range(0, 40)),
                   int'($urandom_range(0, 20)), 3'($urandom_range(0, 7)));
        run_square(100, 42, 21, 3'd5);

        // Random edges
        for (int n = 0; n < 30; n++) begin
            rxs = 7'($urandom_range(0, 127));
            rys = 6'($urandom_range(0, 63));
            rxe = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                              : 7'((int'(rxs) + int'($urandom_range(0, 15)) > 127)
                                                   ? 127 : int'(rxs) + int'($urandom_range(0, 15)));
            rye = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                              : 6'((int'(rys) + int'($urandom_range(0, 15)) > 63)
                                                   ? 63 : int'(rys) + int'($urandom_range(0, 15)));
            run_edge("random", rxs, rxe, rys, rye, 3'($urandom_range(0, 7)),
                     3'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_drawer.md
Name: edge_drawer

Overview:
- Rasterizes one axis-aligned square edge into the 128x64 frame buffer, one pixel per accepted write.
- Sits downstream of the edge calculator. It consumes xstart/xend/ystart/yend/etype, writes pixels, then pulses donedge so the calculator advances to its next edge.
- Runs once per edge; four edges make one square.

Parameters:
- SETTLE, 2, idle cycles after each donedge pulse before new edge inputs are sampled. Covers the calculator's state update plus its output registers.
- COLOR_W, 3, pixel colour width.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- xstart  input  7  edge start column, 0..127.
- xend  input  7  edge end column, 0..127.
- ystart  input  6  edge start row, 0..63.
- yend  input  6  edge end row, 0..63.
- etype  input  3  etype[0]=vertical, etype[1]=horizontal, etype[2]=invalid/offscreen.
- color  input  COLOR_W  pixel colour, sampled with the edge.
- wr_ready  input  1  frame-buffer write grant.
- wr_en  output  1  pixel write request.
- wr_addr  output  13  {y[5:0], x[6:0]}.
- wr_data  output  COLOR_W  pixel colour.
- donedge  output  1  one-cycle pulse: current edge finished.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, wr_en=0, wr_addr=0, wr_data=0, donedge=0, busy=0, all counters 0.
- States: IDLE, DRAW, DONE, SETTLE.
- IDLE:
  - An edge is present when etype[1:0] != 0.
  - On the cycle it is present, capture cur_x=xstart, cur_y=ystart, end_x=xend, end_y=yend, dir=etype[1:0], col=color, inv=etype[2].
  - Next state: DONE if inv=1, or if the edge is degenerate (vertical with ystart>yend, horizontal with xstart>xend). Otherwise DRAW.
  - etype[1:0]=00 or 11: stay IDLE; 11 is treated as no edge.
- DRAW:
  - wr_en=1, wr_addr={cur_y,cur_x}, wr_data=col.
  - wr_en, wr_addr and wr_data are registered outputs. They hold stable while wr_ready=0.
  - A write completes on a cycle with wr_en&wr_ready.
  - On completion, if the current coordinate equals its end value (vertical: cur_y==end_y; horizontal: cur_x==end_x), go to DONE with wr_en=0 on the next cycle.
  - Otherwise increment the walking coordinate by 1 (cur_y for vertical, cur_x for horizontal); the other coordinate is fixed.
  - No wrap: the end check happens before the increment, so x=127 and y=63 never overflow.
- DONE: donedge=1 for exactly one cycle, wr_en=0. Then go to SETTLE with the counter loaded to SETTLE.
- SETTLE:
  - Decrement the counter each cycle and ignore all inputs.
  - Go to IDLE on the cycle the counter reaches 0.
  - SETTLE=0 goes directly DONE->IDLE.
- Latency:
  - Edge present in IDLE at cycle t: first wr_en at t+1.
  - N-pixel edge with wr_ready held high: last write at t+N, donedge at t+N+1.
  - Invalid or degenerate edge: donedge at t+1, zero writes.
- Single-pixel edge (start==end): exactly one write, then donedge.
- Inputs changing during DRAW have no effect; captured values are used.
- Reset asserted mid-DRAW: the write is dropped immediately (wr_en=0 asynchronously) and no donedge is emitted.
- wr_ready low for an extended time: DRAW stalls indefinitely without losing the pending pixel.

Decomposition:
- Shared package holds:
  - ETYPE bit positions (VERT=0, HORZ=1, INV=2).
  - Frame dimensions (X_W=7, Y_W=6, X_MAX=127, Y_MAX=63).
  - State encodings: IDLE=2'b00, DRAW=2'b01, DONE=2'b10, SETTLE=2'b11.
- One natural sub-module: edge_walker, the coordinate counter with the end-compare and the stall/advance logic. The top level holds the FSM and the settle counter.

Test Plan:
- Vertical edge, etype=001, xstart=xend=10, ystart=5, yend=8, wr_ready=1 -> writes at addr {5,10},{6,10},{7,10},{8,10} on 4 consecutive cycles; donedge one cycle later; 4 writes total.
- Horizontal edge, etype=010, x 120..127, y=63 -> 8 writes ending at addr {63,127}; no wrap to x=0; then donedge.
- etype=101 (invalid vertical) -> donedge at t+1, wr_en never asserted; busy low again after SETTLE=2 cycles.
- Horizontal edge x 3..5, wr_ready toggled 1,0,0,1,1 -> addr {y,4} held stable across the 2 stall cycles; exactly 3 writes; donedge after the write of x=5.
- Reset driven low mid-DRAW at pixel 2 of 6 -> wr_en=0 and donedge=0 immediately. After release with etype=000: stays IDLE.
- Four back-to-back edges of a square fed by a calculator model (1-cycle output register) -> all four edges drawn, each sampled only after SETTLE; no edge drawn twice; the 4th donedge pulse coincides with the model's donesquare.
